// File: rtl/fence_sequencer.sv
// Sequences FENCE / FENCE.I / SFENCE.VMA system ops: front-end flush, LSU drain,
// optional per-entry TLB invalidate sweep, fetch redirect and completion pulse.
module fence_sequencer #(
    parameter int TLB_CLEAR_DEPTH = 64,
    parameter int ENABLE_S_MODE   = 1,
    parameter int ID_W            = 3,
    // Derived: width of the TLB invalidate index
    parameter int AW = (TLB_CLEAR_DEPTH > 1) ? $clog2(TLB_CLEAR_DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [1:0]      req_type,
    input  logic [31:0]     req_pc,
    input  logic [ID_W-1:0] req_id,
    output logic            req_ready,
    input  logic            ls_is_idle,
    input  logic            abort,
    output logic            fetch_flush,
    output logic            fetch_hold,
    output logic            issue_hold,
    output logic            pc_override,
    output logic [31:0]     redirect_pc,
    output logic            tlb_clear,
    output logic [AW-1:0]   tlb_clear_addr,
    output logic            done,
    output logic [ID_W-1:0] done_id
);

    localparam logic [1:0] TypeFence  = 2'd0;
    localparam logic [1:0] TypeFenceI = 2'd1;
    localparam logic [1:0] TypeSfence = 2'd2;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StFlush    = 3'd1;
    localparam logic [2:0] StDrain    = 3'd2;
    localparam logic [2:0] StTlbClr   = 3'd3;
    localparam logic [2:0] StRedirect = 3'd4;
    localparam logic [2:0] StDone     = 3'd5;

    localparam logic [AW-1:0] LastAddr = AW'(TLB_CLEAR_DEPTH - 1);
    localparam logic          SModeOn  = (ENABLE_S_MODE != 0);

    logic [2:0]      state_q, state_d;
    logic [1:0]      type_q;
    logic [31:0]     pc_q;
    logic [ID_W-1:0] id_q;
    logic [AW-1:0]   cnt_q;
    logic [31:0]     redirect_pc_q;
    logic [ID_W-1:0] done_id_q;

    logic accept;
    logic front_end_op;  // captured op also invalidates fetched instructions

    assign accept       = (state_q == StIdle) && req_valid;
    assign front_end_op = (type_q == TypeFenceI) || (type_q == TypeSfence);

    // Next-state logic; abort only honoured while flushing or draining
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if ((req_type == TypeFenceI) || (req_type == TypeSfence)) begin
                        state_d = StFlush;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StFlush: begin
                state_d = abort ? StIdle : StDrain;
            end
            StDrain: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (ls_is_idle) begin
                    if ((type_q == TypeSfence) && SModeOn) begin
                        state_d = StTlbClr;
                    end else if (front_end_op) begin
                        state_d = StRedirect;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StTlbClr: begin
                if (cnt_q == LastAddr) begin
                    state_d = StRedirect;
                end
            end
            StRedirect: state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // State, captured request fields, sweep counter and held output values
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            type_q        <= TypeFence;
            pc_q          <= '0;
            id_q          <= '0;
            cnt_q         <= '0;
            redirect_pc_q <= '0;
            done_id_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                type_q <= req_type;
                pc_q   <= req_pc;
                id_q   <= req_id;
            end
            if ((state_q != StTlbClr) && (state_d == StTlbClr)) begin
                cnt_q <= '0;
            end else if (state_q == StTlbClr) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Latch on entry so the value survives back into IDLE
            if ((state_q != StRedirect) && (state_d == StRedirect)) begin
                redirect_pc_q <= pc_q + 32'd4;
            end
            if ((state_q != StDone) && (state_d == StDone)) begin
                done_id_q <= id_q;
            end
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        req_ready      = (state_q == StIdle);
        issue_hold     = (state_q != StIdle);
        fetch_flush    = (state_q == StFlush);
        fetch_hold     = ((state_q == StDrain) || (state_q == StTlbClr)) && front_end_op;
        pc_override    = (state_q == StRedirect);
        tlb_clear      = (state_q == StTlbClr);
        tlb_clear_addr = (state_q == StTlbClr) ? cnt_q : '0;
        done           = (state_q == StDone);
        redirect_pc    = redirect_pc_q;
        done_id        = done_id_q;
    end

endmodule
